// File: rtl/conv_1x1_ofm_writer.sv
// OFM write-back stage for the 1x1 conv: captures PE lanes into a FIFO, writes packed words.
// Optional ReLU clamp at capture when CONV1X1_OFM_RELU_EN is defined.
module conv_1x1_ofm_writer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cal_start,
    input  logic [10:0]         num_filter,
    input  logic [15:0]         num_pixel,
    input  logic [ADDR_W-1:0]   ofm_base,
    input  logic [3:0]          PE_finish,
    input  logic [4*DATA_W-1:0] pe_result,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [4*DATA_W-1:0] wr_data,
    output logic [3:0]          wr_strb,
    output logic                done,
    output logic                overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [3:0]          r_pe_prev;
    logic [10:0]         r_nf;
    logic [15:0]         r_np;
    logic [10:0]         r_grp;
    logic [15:0]         r_pix;
    logic [ADDR_W-1:0]   r_pix_addr;
    logic [ADDR_W-1:0]   r_grp_off;
    logic [4*DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_rd;
    logic [PW-1:0]       r_wr;
    logic [CW-1:0]       r_cnt;
    logic                r_ovf;
    logic                r_wr_valid;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [4*DATA_W-1:0] r_wr_data;
    logic [3:0]          r_wr_strb;

    logic [10:0]         w_nf_n;
    logic [15:0]         w_np_n;
    logic [10:0]         w_grp_n;
    logic [15:0]         w_pix_n;
    logic [ADDR_W-1:0]   w_pix_addr_n;
    logic [ADDR_W-1:0]   w_grp_off_n;
    logic [PW-1:0]       w_rd_n;
    logic [PW-1:0]       w_wr_n;
    logic [CW-1:0]       w_cnt_n;
    logic                w_ovf_n;
    logic                w_valid_n;
    logic [ADDR_W-1:0]   w_addr_n;
    logic [4*DATA_W-1:0] w_data_n;
    logic [3:0]          w_strb_n;

    logic [11:0]         w_groups;
    logic                w_last_grp;
    logic                w_last_pix;
    logic                w_capture;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_bypass;
    logic [4*DATA_W-1:0] w_push_data;

`ifdef CONV1X1_OFM_RELU_EN
    always_comb begin
        w_push_data = '0;
        for (int k = 0; k < 4; k++) begin
            if (!pe_result[k*DATA_W+DATA_W-1])
                w_push_data[k*DATA_W +: DATA_W] = pe_result[k*DATA_W +: DATA_W];
        end
    end
`else
    assign w_push_data = pe_result;
`endif

    assign w_groups   = (12'(r_nf) + 12'd3) >> 2;
    assign w_last_grp = ({1'b0, r_grp} == (w_groups - 12'd1));
    assign w_last_pix = (r_pix == (r_np - 16'd1));

    // Rising edge of the all-lanes-finished condition
    assign w_capture = (PE_finish == 4'hF) && (r_pe_prev != 4'hF)
                       && (r_state == S_RUN);
    assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
    assign w_push    = w_capture && !w_full && cal_start;
    assign w_drop    = w_capture && w_full;
    assign w_pop     = r_wr_valid && wr_ready
                       && (r_state == S_RUN) && cal_start;
    // Entry presented next cycle is the one being pushed right now
    assign w_bypass  = w_push && ((r_cnt - CW'(w_pop)) == '0);

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cal_start)
                    w_state_n = (num_filter == '0 || num_pixel == '0)
                              ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (!cal_start)
                    w_state_n = S_IDLE;
                else if (w_pop && w_last_grp && w_last_pix)
                    w_state_n = S_DONE;
            end
            S_DONE: begin
                if (!cal_start)
                    w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        w_nf_n       = r_nf;
        w_np_n       = r_np;
        w_grp_n      = r_grp;
        w_pix_n      = r_pix;
        w_pix_addr_n = r_pix_addr;
        w_grp_off_n  = r_grp_off;
        w_rd_n       = '0;
        w_wr_n       = '0;
        w_cnt_n      = '0;
        w_ovf_n      = r_ovf;
        w_valid_n    = 1'b0;
        w_addr_n     = '0;
        w_data_n     = '0;
        w_strb_n     = '0;
        if (r_state == S_IDLE && cal_start) begin
            w_nf_n       = num_filter;
            w_np_n       = num_pixel;
            w_grp_n      = '0;
            w_pix_n      = '0;
            w_pix_addr_n = ofm_base;
            w_grp_off_n  = '0;
            w_ovf_n      = 1'b0;
        end else if (r_state == S_RUN && w_state_n == S_RUN) begin
            w_rd_n  = r_rd + PW'(w_pop);
            w_wr_n  = r_wr + PW'(w_push);
            w_cnt_n = r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_drop)
                w_ovf_n = 1'b1;
            if (w_pop) begin
                if (w_last_grp) begin
                    w_grp_n      = '0;
                    w_grp_off_n  = '0;
                    w_pix_n      = r_pix + 16'd1;
                    w_pix_addr_n = r_pix_addr + ADDR_W'(r_nf);
                end else begin
                    w_grp_n     = r_grp + 11'd1;
                    w_grp_off_n = r_grp_off + ADDR_W'(4);
                end
            end
            w_valid_n = (w_cnt_n != '0);
            if (w_valid_n) begin
                w_addr_n = w_pix_addr_n + w_grp_off_n;
                w_data_n = w_bypass ? w_push_data : r_mem[w_rd_n];
                if (({1'b0, w_grp_n} == (w_groups - 12'd1))
                    && (r_nf[1:0] != 2'd0))
                    w_strb_n = (4'b0001 << r_nf[1:0]) - 4'd1;
                else
                    w_strb_n = 4'hF;
            end
        end else if (r_state == S_RUN) begin
            w_grp_n      = '0;
            w_pix_n      = '0;
            w_pix_addr_n = '0;
            w_grp_off_n  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pe_prev  <= '0;
            r_nf       <= '0;
            r_np       <= '0;
            r_grp      <= '0;
            r_pix      <= '0;
            r_pix_addr <= '0;
            r_grp_off  <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_strb  <= '0;
        end else begin
            r_pe_prev  <= PE_finish;
            r_nf       <= w_nf_n;
            r_np       <= w_np_n;
            r_grp      <= w_grp_n;
            r_pix      <= w_pix_n;
            r_pix_addr <= w_pix_addr_n;
            r_grp_off  <= w_grp_off_n;
            r_rd       <= w_rd_n;
            r_wr       <= w_wr_n;
            r_cnt      <= w_cnt_n;
            r_ovf      <= w_ovf_n;
            r_wr_valid <= w_valid_n;
            r_wr_addr  <= w_addr_n;
            r_wr_data  <= w_data_n;
            r_wr_strb  <= w_strb_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr] <= w_push_data;
        end
    end

    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign wr_strb  = r_wr_strb;
    assign done     = (r_state == S_DONE);
    assign overflow = r_ovf;

endmodule
